fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning PC and instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all entries (branch redirect / trap).
REQ-006 SHALL have port push_valid  input  1  fetch side presents a PC/instruction pair.
REQ-007 SHALL have port push_ready  output  1  queue accepts the pair this cycle.
REQ-008 SHALL have port push_pc  input  XLEN  PC of the fetched word.
REQ-009 SHALL have port push_inst  input  XLEN  fetched instruction word.
REQ-010 SHALL have port pop_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port pop_ready  input  1  decode consumes the head this cycle.
REQ-012 SHALL have port pop_pc  output  XLEN  PC of the head entry.
REQ-013 SHALL have port pop_inst  output  XLEN  instruction of the head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port flush_drops  output  8  saturating count of valid entries discarded by flushes.

Function
REQ-016 SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-017 SHALL accept an entry when push_valid && push_ready; SHALL drop no accepted entry.
REQ-018 SHALL retire the head when pop_valid && pop_ready; entries leave in push order.
REQ-019 SHALL drive push_ready = (count != DEPTH) && !flush; no pass-through when full.
REQ-020 SHALL drive pop_valid = (count != 0) && !flush, except as extended by REQ-033.
REQ-021 SHALL drive pop_pc and pop_inst to 0 whenever pop_valid is 0.
REQ-022 SHALL leave count unchanged on simultaneous push and pop; SHALL increment on push only; SHALL decrement on pop only.
REQ-023 SHALL, on flush, set count to 0 and both pointers to 0 at the next edge; same-cycle push and pop are ignored (flush has priority).
REQ-024 SHALL, on flush, add the pre-flush count to flush_drops, saturating at 255.
REQ-025 SHALL have minimum latency of one cycle from accepted push to pop_valid when FETCHQ_BYPASS_EN is not defined.
REQ-026 SHALL keep pop_pc/pop_inst stable while pop_valid=1 and pop_ready=0.
REQ-027 SHALL treat push_valid=1 while full as a stall; the fetch side holds its data.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, clear pointers, count=0, flush_drops=0.
REQ-029 SHALL, after reset, present push_ready=1, pop_valid=0, pop_pc=0, pop_inst=0.
REQ-030 SHALL give rst priority over flush, push and pop; reset mid-stream discards all entries without updating flush_drops.
REQ-031 SHALL NOT require the storage array to be cleared by reset.

Configuration
REQ-032 SHALL use macro FETCHQ_BYPASS_EN to select empty-queue bypass.
REQ-033 SHALL, with FETCHQ_BYPASS_EN defined, when count=0 and push_valid=1 and flush=0, drive pop_valid=1 with pop_pc/pop_inst equal to push_pc/push_inst in the same cycle; if pop_ready=1 the entry is not stored and count stays 0.
REQ-034 SHALL, without FETCHQ_BYPASS_EN, never combinationally route push data to pop outputs.

Verification
REQ-035 SHALL pass: reset, push pc=0x0 inst=0x03208093 with pop_ready=0 -> next cycle pop_valid=1, pop_pc=0x0, pop_inst=0x03208093, count=1.
REQ-036 SHALL pass: push pcs 0x0,0x4,0x8,0xC with pop_ready=0 (DEPTH=4) -> count=4, push_ready=0; fifth push stalls; then pop_ready=1 pops 0x0,0x4,0x8,0xC in order.
REQ-037 SHALL pass: count=2, push and pop same cycle for 10 cycles -> count stays 2, output PCs strictly increment by 4, pointers wrap without loss.
REQ-038 SHALL pass: count=3, flush=1 with push_valid=1 -> next cycle count=0, pop_valid=0, flush_drops=3; pushed word not stored.
REQ-039 SHALL pass: rst=1 asserted with count=2 -> next cycle count=0, pop_valid=0, pop_inst=0, flush_drops unchanged at 0.
REQ-040 SHALL pass (FETCHQ_BYPASS_EN defined): empty queue, push pc=0x10 inst=0x00000073 with pop_ready=1 -> same cycle pop_valid=1, pop_pc=0x10; next cycle count=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue: push side from fetch, pop side to decode.
// master = the environment (fetch + decode), slave = the queue itself.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] push_pc;
  logic [XLEN-1:0] push_inst;
  logic            pop_valid;
  logic            pop_ready;
  logic [XLEN-1:0] pop_pc;
  logic [XLEN-1:0] pop_inst;

  modport master (
    output push_valid, push_pc, push_inst, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_inst
  );

  modport slave (
    input  push_valid, push_pc, push_inst, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular PC/instruction queue between fetch and decode, with flush and a saturating drop counter.
// Optional build macro FETCHQ_BYPASS_EN: an empty queue forwards the pushed pair to decode in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_queue_if.slave             fq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               flush_drops
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      drops_q, drops_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic            empty, full, bypass;
  logic            push_rdy, pop_vld;
  logic [XLEN-1:0] pop_pc_c, pop_inst_c;
  logic            push_fire, pop_fire, store, retire;
  logic [8:0]      drops_sum;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    push_rdy = !full && !flush;
    bypass   = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass   = empty && fq.push_valid && !flush;
`else
    bypass   = 1'b0;
`endif
    pop_vld    = (!empty && !flush) || bypass;
    pop_pc_c   = '0;
    pop_inst_c = '0;
    if (!empty && !flush) begin
      pop_pc_c   = pc_mem[rd_ptr_q];
      pop_inst_c = inst_mem[rd_ptr_q];
    end else if (bypass) begin
      pop_pc_c   = fq.push_pc;
      pop_inst_c = fq.push_inst;
    end

    push_fire = fq.push_valid && push_rdy;
    pop_fire  = pop_vld && fq.pop_ready;
    // A bypassed pair consumed in the same cycle never touches the storage.
    store     = push_fire && !(bypass && pop_fire);
    retire    = pop_fire && !bypass;

    rd_ptr_d = rd_ptr_q + PW'(retire);
    wr_ptr_d = wr_ptr_q + PW'(store);
    count_d  = count_q;
    case ({store, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    drops_sum = {1'b0, drops_q} + 9'(count_q);
    drops_d   = drops_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drops_d  = drops_sum[8] ? 8'hFF : drops_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr_q]   <= fq.push_pc;
      inst_mem[wr_ptr_q] <= fq.push_inst;
    end
  end

  assign fq.push_ready = push_rdy;
  assign fq.pop_valid  = pop_vld;
  assign fq.pop_pc     = pop_pc_c;
  assign fq.pop_inst   = pop_inst_c;
  assign count         = count_q;
  assign flush_drops   = drops_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, XLEN=32): vector table plus hand-written
// sequences for wrap-around streaming, flush, drop saturation and the empty-queue path.
module tb_fetch_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic [7:0] flush_drops;

  int tests = 0;
  int fails = 0;

  fetch_queue_if #(.XLEN(32)) fq_if ();

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fq          (fq_if),
    .count       (count),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        pv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pr;
    logic [2:0]  e_count;
    logic        e_prdy;
    logic        e_pv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [7:0]  e_drops;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic pv, logic [31:0] pc, logic [31:0] inst,
                              logic pr, logic [2:0] ec, logic eprdy, logic epv,
                              logic [31:0] epc, logic [31:0] einst, logic [7:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.pv = pv; v.pc = pc; v.inst = inst; v.pr = pr;
    v.e_count = ec; v.e_prdy = eprdy; v.e_pv = epv; v.e_pc = epc; v.e_inst = einst; v.e_drops = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    fq_if.push_valid = 1'b0; fq_if.push_pc = '0; fq_if.push_inst = '0; fq_if.pop_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input vec_t v);
    check({tag, ".count"},       32'(count),             32'(v.e_count));
    check({tag, ".push_ready"},  32'(fq_if.push_ready),  32'(v.e_prdy));
    check({tag, ".pop_valid"},   32'(fq_if.pop_valid),   32'(v.e_pv));
    check({tag, ".pop_pc"},      fq_if.pop_pc,           v.e_pc);
    check({tag, ".pop_inst"},    fq_if.pop_inst,         v.e_inst);
    check({tag, ".flush_drops"}, 32'(flush_drops),       32'(v.e_drops));
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    fq_if.push_valid = 1'b1; fq_if.push_pc = pc; fq_if.push_inst = inst;
    step();
    idle();
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    idle();
    #1;
  endtask

  vec_t vecs [14];
  int   exp_drops;

  initial begin
    // push/pop table; expectations are the state after the edge with inputs back at idle
    vecs[0]  = mk(0,0,1,32'h00,32'h03208093,0, 3'd1,1,1,32'h00,32'h03208093,8'd0);
    vecs[1]  = mk(0,0,1,32'h04,32'h00400113,0, 3'd2,1,1,32'h00,32'h03208093,8'd0);
    vecs[2]  = mk(0,0,1,32'h08,32'h00800193,0, 3'd3,1,1,32'h00,32'h03208093,8'd0);
    vecs[3]  = mk(0,0,1,32'h0C,32'h00c00213,0, 3'd4,0,1,32'h00,32'h03208093,8'd0);
    vecs[4]  = mk(0,0,1,32'h10,32'h01000293,0, 3'd4,0,1,32'h00,32'h03208093,8'd0);
    vecs[5]  = mk(0,0,0,32'h00,32'h00000000,1, 3'd3,1,1,32'h04,32'h00400113,8'd0);
    vecs[6]  = mk(0,0,0,32'h00,32'h00000000,1, 3'd2,1,1,32'h08,32'h00800193,8'd0);
    vecs[7]  = mk(0,0,0,32'h00,32'h00000000,1, 3'd1,1,1,32'h0C,32'h00c00213,8'd0);
    vecs[8]  = mk(0,0,0,32'h00,32'h00000000,1, 3'd0,1,0,32'h00,32'h00000000,8'd0);
    vecs[9]  = mk(0,0,0,32'h00,32'h00000000,1, 3'd0,1,0,32'h00,32'h00000000,8'd0);
    vecs[10] = mk(0,1,0,32'h00,32'h00000000,0, 3'd0,1,0,32'h00,32'h00000000,8'd0);
    vecs[11] = mk(0,0,1,32'h14,32'h00000011,0, 3'd1,1,1,32'h14,32'h00000011,8'd0);
    vecs[12] = mk(0,0,1,32'h18,32'h00000022,0, 3'd2,1,1,32'h14,32'h00000011,8'd0);
    vecs[13] = mk(1,0,1,32'h1C,32'h00000033,0, 3'd0,1,0,32'h00,32'h00000000,8'd0);

    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_state("reset", mk(0,0,0,0,0,0, 3'd0,1,0,32'h0,32'h0,8'd0));

`ifdef FETCHQ_BYPASS_EN
    fq_if.push_valid = 1'b1; fq_if.push_pc = 32'h10; fq_if.push_inst = 32'h00000073; fq_if.pop_ready = 1'b1;
    #1;
    check("bypass.pop_valid", 32'(fq_if.pop_valid), 32'd1);
    check("bypass.pop_pc",    fq_if.pop_pc,         32'h10);
    check("bypass.pop_inst",  fq_if.pop_inst,       32'h00000073);
    step();
    idle();
    #1;
    check("bypass.count_after", 32'(count), 32'd0);
    $display("[TB] bypass transaction pc=0x10");
`else
    fq_if.push_valid = 1'b1; fq_if.push_pc = 32'h0; fq_if.push_inst = 32'h03208093;
    #1;
    check("no_bypass.pop_valid", 32'(fq_if.pop_valid), 32'd0);
    check("no_bypass.pop_pc",    fq_if.pop_pc,         32'h0);
    idle();
    #1;
`endif

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush;
      fq_if.push_valid = vecs[i].pv; fq_if.push_pc = vecs[i].pc;
      fq_if.push_inst = vecs[i].inst; fq_if.pop_ready = vecs[i].pr;
      step();
      idle();
      #1;
      check_state($sformatf("vec%0d", i), vecs[i]);
      $display("[TB] vec%0d rst=%0b flush=%0b push=%0b pc=0x%0h pop=%0b -> count=%0d head=0x%0h",
               i, vecs[i].rst, vecs[i].flush, vecs[i].pv, vecs[i].pc, vecs[i].pr, count, fq_if.pop_pc);
    end

    // steady streaming at count=2, pointers wrap several times
    push(32'h20, 32'h20 | 32'h13);
    push(32'h24, 32'h24 | 32'h13);
    check("stream.start_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      fq_if.push_valid = 1'b1;
      fq_if.push_pc    = 32'h28 + 32'(4 * i);
      fq_if.push_inst  = (32'h28 + 32'(4 * i)) | 32'h13;
      fq_if.pop_ready  = 1'b1;
      #1;
      check($sformatf("stream%0d.pop_pc", i),   fq_if.pop_pc,   32'h20 + 32'(4 * i));
      check($sformatf("stream%0d.pop_inst", i), fq_if.pop_inst, (32'h20 + 32'(4 * i)) | 32'h13);
      step();
      check($sformatf("stream%0d.count", i), 32'(count), 32'd2);
      $display("[TB] stream%0d push=0x%0h pop=0x%0h", i, 32'h28 + 32'(4 * i), 32'h20 + 32'(4 * i));
    end
    idle();
    #1;
    check("stream.head_after", fq_if.pop_pc, 32'h48);

    // flush with a simultaneous push at count=3
    push(32'h50, 32'h50 | 32'h13);
    check("flush.pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    fq_if.push_valid = 1'b1; fq_if.push_pc = 32'h54; fq_if.push_inst = 32'h54 | 32'h13;
    #1;
    check("flush.push_ready_during", 32'(fq_if.push_ready), 32'd0);
    check("flush.pop_valid_during",  32'(fq_if.pop_valid),  32'd0);
    step();
    idle();
    #1;
    check_state("flush", mk(0,0,0,0,0,0, 3'd0,1,0,32'h0,32'h0,8'd3));
    $display("[TB] flush count=3 drops=%0d", flush_drops);

    // drop counter saturation: rounds of four pushes then a flush
    exp_drops = 3;
    for (int r = 1; r <= 64; r++) begin
      for (int k = 0; k < 4; k++) push(32'h100 + 32'(4 * k), 32'(k));
      do_flush();
      exp_drops = (exp_drops + 4 > 255) ? 255 : exp_drops + 4;
      if (r == 1 || r == 62 || r == 63 || r == 64) begin
        check($sformatf("sat_round%0d.drops", r), 32'(flush_drops), 32'(exp_drops));
        check($sformatf("sat_round%0d.count", r), 32'(count), 32'd0);
        $display("[TB] saturation round %0d drops=%0d", r, flush_drops);
      end
    end

    // reset with the counter saturated clears it
    push(32'h200, 32'h1);
    rst = 1'b1;
    step();
    idle();
    #1;
    check_state("rst_sat", mk(0,0,0,0,0,0, 3'd0,1,0,32'h0,32'h0,8'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
